// File: rtl/timer_pkg.sv
// Shared types, defaults and the round-robin pick used by the timer scheduler.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;

  localparam int NUM_REQ_DEFAULT   = 4;
  localparam int CNT_WIDTH_DEFAULT = 16;
  // Widest requester vector rr_pick handles; narrower vectors are zero-extended.
  localparam int RR_MAX            = 8;

  // First set bit searching from ptr+1 upward with wrap. Scanning offsets from
  // far to near lets the nearest hit overwrite the others. With no bit set,
  // ptr comes back unchanged.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                nreq);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = ptr;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= nreq) begin
        idx = 3'((int'(ptr) + k) % nreq);
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/timer_scheduler_delay_counter.sv
// Loadable down-counter that stops at zero; flags the last counted cycle.
module delay_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 at_one
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Next count: load wins over decrement; never step below zero.
  always_comb begin
    count_d = count_q;
    if (load)                     count_d = load_val;
    else if (en && count_q != '0) count_d = count_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count  = count_q;
  assign at_one = (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/timer_scheduler.sv
// One countdown timer shared round-robin among NUM_REQ requesters.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] req_duration,
  input  logic                         abort,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done_signal,
  output logic                         busy,
  output logic [ID_W-1:0]              active_id
);

  timer_state_t         state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 cnt_load, cnt_en, cnt_at_one;
  logic [CNT_WIDTH-1:0] cnt_val, cnt_load_val, win_dur;
  logic [ID_W-1:0]      winner;

  assign winner       = ID_W'(rr_pick(RR_MAX'(req), 3'(ptr_q), NUM_REQ));
  assign win_dur      = req_duration[winner*CNT_WIDTH +: CNT_WIDTH];
  // Zero means "as short as possible", which is one cycle.
  assign cnt_load_val = (win_dur == '0) ? CNT_WIDTH'(1) : win_dur;

  delay_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (cnt_val),
    .at_one   (cnt_at_one)
  );

  // Next-state and output decode. DONE also arbitrates so a new grant can
  // follow the done pulse directly (ptr already points at the finished owner).
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = '0;
    done_d   = '0;
    busy_d   = busy_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (|req) begin
          state_d  = RUN;
          grant_d  = NUM_REQ'(1) << winner;
          owner_d  = winner;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          // Abort beats expiry when both land on the same cycle.
          state_d = IDLE;
          busy_d  = 1'b0;
          ptr_d   = owner_q;
        end else if (cnt_at_one || cnt_val == '0) begin
          state_d = DONE;
          done_d  = NUM_REQ'(1) << owner_q;
          busy_d  = 1'b0;
          ptr_d   = owner_q;
        end else begin
          cnt_en  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any delay in flight silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign done_signal = done_q;
  assign busy        = busy_q;
  assign active_id   = owner_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: one task per scenario, inline checks.
module tb_timer_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_duration;
  logic        abort;
  logic [3:0]  grant;
  logic [3:0]  done_signal;
  logic        busy;
  logic [1:0]  active_id;

  int checks = 0;
  int errors = 0;

  timer_scheduler #(.NUM_REQ(4), .CNT_WIDTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_duration (req_duration),
    .abort        (abort),
    .grant        (grant),
    .done_signal  (done_signal),
    .busy         (busy),
    .active_id    (active_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_dur(input int i, input logic [15:0] v);
    req_duration[i*16 +: 16] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; abort = 1'b0;
    for (int i = 0; i < 4; i++) set_dur(i, 16'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({grant, done_signal, busy, active_id} !== 11'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: grant=%b done=%b busy=%b id=%0d want all 0",
                 c, grant, done_signal, busy, active_id);
      end
    end
    req = 4'b0000;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0010; set_dur(1, 16'd5);
    tick();  // cycle g
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1 || active_id !== 2'd1) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b id=%0d want 0010 1 1", grant, busy, active_id);
    end
    req = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || done_signal !== 4'b0000 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL single_run g+%0d: busy=%b done=%b grant=%b want 1 0000 0000",
                 c, busy, done_signal, grant);
      end
    end
    tick();  // g+5
    checks++;
    if (done_signal !== 4'b0010 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b want 0010 0", done_signal, busy);
    end
    tick();
    checks++;
    if (done_signal !== 4'b0000) begin
      errors++;
      $display("FAIL single_done_pulse: done=%b want 0000", done_signal);
    end
  endtask

  task automatic test_zero_duration();
    req = 4'b0100; set_dur(2, 16'd0);
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL zero_grant: grant=%b want 0100", grant);
    end
    req = 4'b0000;
    tick();  // g+1
    checks++;
    if (done_signal !== 4'b0100 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b want 0100 0", done_signal, busy);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] order [6];
    order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 4; i++) set_dur(i, 16'd2);
    // Serve requester 3 alone first so the pointer starts at 3.
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL rr_prime_grant: grant=%b want 1000", grant);
    end
    req = 4'b1011;
    tick();
    tick();
    checks++;
    if (done_signal !== 4'b1000) begin
      errors++;
      $display("FAIL rr_prime_done: done=%b want 1000", done_signal);
    end
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (grant !== (4'b0001 << order[n]) || active_id !== order[n]) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b id=%0d want id %0d", n, grant, active_id, order[n]);
      end
      tick();
      tick();
      checks++;
      if (done_signal !== (4'b0001 << order[n])) begin
        errors++;
        $display("FAIL rr_done%0d: done=%b want id %0d", n, done_signal, order[n]);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    req = 4'b0001; set_dur(0, 16'd10); set_dur(2, 16'd3);
    tick();  // g
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL abort_grant: grant=%b want 0001", grant);
    end
    req = 4'b0101;  // requester 2 arrives while running
    for (int c = 1; c <= 4; c++) tick();
    abort = 1'b1;   // held during cycle g+4
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: busy=%b want 1", busy);
    end
    tick();  // g+5
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done_signal !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b want 0 0000", busy, done_signal);
    end
    tick();  // pending requester 2 picked up from IDLE
    checks++;
    if (grant !== 4'b0100 || active_id !== 2'd2) begin
      errors++;
      $display("FAIL abort_next_grant: grant=%b id=%0d want 0100 2", grant, active_id);
    end
    req = 4'b0000;
    tick();
    tick();
    checks++;
    if (done_signal !== 4'b0000) begin
      errors++;
      $display("FAIL abort_no_done: done=%b want 0000", done_signal);
    end
    tick();
    checks++;
    if (done_signal !== 4'b0100) begin
      errors++;
      $display("FAIL abort_next_done: done=%b want 0100", done_signal);
    end
    tick();
    // Abort on the same cycle the counter hits 1: abort must win.
    req = 4'b0010; set_dur(1, 16'd2);
    tick();  // g
    req = 4'b0000;
    tick();  // g+1, count == 1
    abort = 1'b1;
    tick();  // g+2
    abort = 1'b0;
    checks++;
    if (done_signal !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_collide: done=%b busy=%b want 0000 0", done_signal, busy);
    end
    tick();
    checks++;
    if (done_signal !== 4'b0000) begin
      errors++;
      $display("FAIL abort_collide_late: done=%b want 0000", done_signal);
    end
  endtask

  task automatic test_reset_mid_and_max();
    bit saw_done;
    int n;
    req = 4'b0100; set_dur(2, 16'd8);
    tick();  // g
    req = 4'b0000;
    tick(); tick(); tick();  // g+3
    reset = 1'b1;
    tick();
    checks++;
    if ({grant, done_signal, busy, active_id} !== 11'b0) begin
      errors++;
      $display("FAIL midreset_outputs: grant=%b done=%b busy=%b id=%0d want all 0",
               grant, done_signal, busy, active_id);
    end
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done_signal !== 4'b0000 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midreset_quiet: got activity after reset want none");
    end
    set_dur(0, 16'hFFFF);
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || active_id !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_grant: grant=%b id=%0d want 0001 0", grant, active_id);
    end
    req = 4'b0000;
    n = 0;
    for (int c = 1; c <= 70000; c++) begin
      tick();
      if (done_signal !== 4'b0000) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != 65535 || done_signal !== 4'b0001) begin
      errors++;
      $display("FAIL max_duration: done after %0d cycles (done=%b) want 65535 0001", n, done_signal);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done_signal !== 4'b0000) begin
      errors++;
      $display("FAIL max_after: busy=%b done=%b want 0 0000", busy, done_signal);
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_duration = '0; abort = 1'b0;
    test_reset();
    test_single();
    test_zero_duration();
    test_round_robin();
    test_abort();
    test_reset_mid_and_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
